// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I constants and types for the memory stage.
//   - OPCODE_LOAD / OPCODE_STORE major opcodes
//   - F3_* load/store width selectors
//   - mem_state_e: memory-stage FSM states
//   - is_misaligned(): alignment check used when MEM_MISALIGN_TRAP_EN is defined
package riscv_pkg;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } mem_state_e;

    // BU/HU are not valid store widths, so a store with those codes is a word access.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] off,
                                           input logic       is_store);
        logic r;
        r = (off != 2'b00);
        case (funct3)
            F3_B:    r = 1'b0;
            F3_H:    r = off[0];
            F3_BU:   if (!is_store) r = 1'b0;
            F3_HU:   if (!is_store) r = off[0];
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align: combinational lane steering for the data-memory port.
//   funct3     in  width/sign selector
//   off        in  byte offset (address bits [1:0])
//   store_data in  rs2 value for stores
//   load_rdata in  raw word returned by memory
//   st_be      out store byte enables (SB/SH/SW lane rules)
//   st_wdata   out lane-replicated store data
//   ld_data    out extracted and sign/zero-extended load data
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_rdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (funct3)
            F3_B: begin
                st_be    = 4'b0001 << off;
                st_wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                st_be    = 4'b0011 << {off[1], 1'b0};
                st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = load_rdata[{off, 3'b000} +: 8];
        ld_half = off[1] ? load_rdata[31:16] : load_rdata[15:0];
        case (funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'b0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'b0, ld_half};
            default: ld_data = load_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I memory stage, producer side of MEM->WB.
//   ex_*      in  execute-stage instruction bundle (held by upstream while mem_stall)
//   mem_stall out stage busy with a memory transaction
//   dmem_*    req/gnt/rvalid data-memory port; dmem_addr is word aligned
//   wb_*      out registered writeback bundle (wb_lmd = extended load data)
//   misalign_exc out misaligned-access flag, valid with wb_valid
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// instead of forcing them aligned; when undefined misalign_exc is tied 0.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    output logic            mem_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [6:0]      wb_opcode,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_lmd,
    output logic [4:0]      wb_rd,
    output logic            wb_write_en,
    output logic            misalign_exc
);

    mem_state_e      state;
    logic [XLEN-1:0] lat_alu;
    logic [XLEN-1:0] lat_wdata;
    logic [3:0]      lat_be;
    logic            lat_we;
    logic [6:0]      lat_opcode;
    logic [4:0]      lat_rd;
    logic            lat_reg_write;
    logic [2:0]      lat_funct3;

    logic            accept;
    logic            is_store;
    logic            is_mem;
    logic            trap;
    logic [2:0]      align_funct3;
    logic [1:0]      align_off;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;

    assign mem_stall = (state != IDLE);
    assign accept    = ex_valid && !mem_stall;
    assign is_store  = (ex_opcode == OPCODE_STORE);
    assign is_mem    = is_store || (ex_opcode == OPCODE_LOAD);

    assign dmem_req   = (state == REQ);
    assign dmem_we    = lat_we && (state == REQ);
    assign dmem_addr  = {lat_alu[XLEN-1:2], 2'b00};
    assign dmem_be    = lat_be;
    assign dmem_wdata = lat_wdata;

    // One aligner serves both directions: in IDLE it steers the incoming store,
    // otherwise it extracts the returning load using the latched width/offset.
    assign align_funct3 = mem_stall ? lat_funct3 : ex_funct3;
    assign align_off    = mem_stall ? lat_alu[1:0] : ex_alu_result[1:0];

    load_store_align u_align (
        .funct3     (align_funct3),
        .off        (align_off),
        .store_data (ex_store_data),
        .load_rdata (dmem_rdata),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_data    (ld_data)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap = accept && is_mem &&
                  is_misaligned(ex_funct3, ex_alu_result[1:0], is_store);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= trap;
    end

    assign misalign_exc = misalign_q;
`else
    assign trap         = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lat_alu       <= '0;
            lat_wdata     <= '0;
            lat_be        <= '0;
            lat_we        <= 1'b0;
            lat_opcode    <= '0;
            lat_rd        <= '0;
            lat_reg_write <= 1'b0;
            lat_funct3    <= '0;
            wb_valid      <= 1'b0;
            wb_opcode     <= '0;
            wb_alu_result <= '0;
            wb_lmd        <= '0;
            wb_rd         <= '0;
            wb_write_en   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (trap) begin
                            wb_valid      <= 1'b1;
                            wb_opcode     <= ex_opcode;
                            wb_alu_result <= ex_alu_result;
                            wb_lmd        <= '0;
                            wb_rd         <= ex_rd;
                            wb_write_en   <= 1'b0;
                        end else if (is_mem) begin
                            lat_alu       <= ex_alu_result;
                            lat_wdata     <= st_wdata;
                            lat_be        <= is_store ? st_be : 4'b1111;
                            lat_we        <= is_store;
                            lat_opcode    <= ex_opcode;
                            lat_rd        <= ex_rd;
                            lat_reg_write <= ex_reg_write;
                            lat_funct3    <= ex_funct3;
                            state         <= REQ;
                        end else begin
                            wb_valid      <= 1'b1;
                            wb_opcode     <= ex_opcode;
                            wb_alu_result <= ex_alu_result;
                            wb_lmd        <= '0;
                            wb_rd         <= ex_rd;
                            wb_write_en   <= ex_reg_write;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        if (lat_we) begin
                            wb_valid      <= 1'b1;
                            wb_opcode     <= lat_opcode;
                            wb_alu_result <= lat_alu;
                            wb_lmd        <= '0;
                            wb_rd         <= lat_rd;
                            wb_write_en   <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (dmem_rvalid) begin
                        wb_valid      <= 1'b1;
                        wb_opcode     <= lat_opcode;
                        wb_alu_result <= lat_alu;
                        wb_lmd        <= ld_data;
                        wb_rd         <= lat_rd;
                        wb_write_en   <= lat_reg_write;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
// Builds with or without MEM_MISALIGN_TRAP_EN; the misaligned-access step
// checks whichever behaviour the build selects.
module tb_mem_access_stage;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [6:0]  wb_opcode;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_lmd;
    logic [4:0]  wb_rd;
    logic        wb_write_en;
    logic        misalign_exc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_funct3     (ex_funct3),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_stall     (mem_stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_opcode     (wb_opcode),
        .wb_alu_result (wb_alu_result),
        .wb_lmd        (wb_lmd),
        .wb_rd         (wb_rd),
        .wb_write_en   (wb_write_en),
        .misalign_exc  (misalign_exc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_ex(input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] sdata,
                            input logic [4:0] rd, input logic rw);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_funct3     = f3;
        ex_alu_result = alu;
        ex_store_data = sdata;
        ex_rd         = rd;
        ex_reg_write  = rw;
    endtask

    // Load with gnt in the first REQ cycle and rvalid the cycle after.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata);
        drive_ex(OP_LOAD, f3, addr, 32'h0, rd, 1'b1);
        tick();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_opcode = '0; ex_funct3 = '0; ex_alu_result = '0;
        ex_store_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_mem_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_exc}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_wb_lmd", wb_lmd, 32'h0);
        rst_n = 1'b1;
        tick();

        // Non-memory op: one-cycle latency, no stall
        drive_ex(OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        chk("add_stall_pre", {31'b0, mem_stall}, 32'd0);
        tick();
        ex_valid = 1'b0;
        chk("add_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("add_wb_alu", wb_alu_result, 32'h0000_1234);
        chk("add_wb_rd", {27'b0, wb_rd}, 32'd5);
        chk("add_wb_we", {31'b0, wb_write_en}, 32'd1);
        chk("add_wb_lmd", wb_lmd, 32'h0);
        chk("add_wb_opcode", {25'b0, wb_opcode}, {25'b0, OP_ALU});
        chk("add_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        chk("idle_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("idle_wb_rd_hold", {27'b0, wb_rd}, 32'd5);

        // SB 0x103 with gnt held off for two REQ cycles; reg_write forced low
        drive_ex(OP_STORE, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd9, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("sb_req", {31'b0, dmem_req}, 32'd1);
        chk("sb_we", {31'b0, dmem_we}, 32'd1);
        chk("sb_stall", {31'b0, mem_stall}, 32'd1);
        chk("sb_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("sb_be", {28'b0, dmem_be}, 32'b1000);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", dmem_addr, 32'h0000_0100);
        tick();
        chk("sb_req_wait", {31'b0, dmem_req}, 32'd1);
        chk("sb_addr_hold", dmem_addr, 32'h0000_0100);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("sb_done_valid", {31'b0, wb_valid}, 32'd1);
        chk("sb_done_we", {31'b0, wb_write_en}, 32'd0);
        chk("sb_done_req", {31'b0, dmem_req}, 32'd0);
        chk("sb_done_stall", {31'b0, mem_stall}, 32'd0);
        chk("sb_done_alu", wb_alu_result, 32'h0000_0103);

        // SH 0x002: upper half lane
        drive_ex(OP_STORE, 3'b001, 32'h0000_0002, 32'h1234_BEEF, 5'd0, 1'b0);
        tick();
        ex_valid = 1'b0;
        chk("sh_be", {28'b0, dmem_be}, 32'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", dmem_addr, 32'h0000_0000);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("sh_done_valid", {31'b0, wb_valid}, 32'd1);

        // LB 0x102, stepwise with stall observation
        drive_ex(OP_LOAD, 3'b000, 32'h0000_0102, 32'h0, 5'd7, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("lb_req", {31'b0, dmem_req}, 32'd1);
        chk("lb_we", {31'b0, dmem_we}, 32'd0);
        chk("lb_stall_req", {31'b0, mem_stall}, 32'd1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("lb_waitr_req", {31'b0, dmem_req}, 32'd0);
        chk("lb_stall_waitr", {31'b0, mem_stall}, 32'd1);
        chk("lb_waitr_valid", {31'b0, wb_valid}, 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0080_0000;
        tick();
        dmem_rvalid = 1'b0;
        chk("lb_valid", {31'b0, wb_valid}, 32'd1);
        chk("lb_lmd", wb_lmd, 32'hFFFF_FF80);
        chk("lb_we_out", {31'b0, wb_write_en}, 32'd1);
        chk("lb_rd", {27'b0, wb_rd}, 32'd7);
        chk("lb_stall_done", {31'b0, mem_stall}, 32'd0);

        // LBU 0x102, with a stray rvalid during REQ that must be ignored
        drive_ex(OP_LOAD, 3'b100, 32'h0000_0102, 32'h0, 5'd8, 1'b1);
        tick();
        ex_valid    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid = 1'b0;
        chk("lbu_req_rvalid_ign", {31'b0, dmem_req}, 32'd1);
        chk("lbu_req_wb_valid", {31'b0, wb_valid}, 32'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        tick();
        chk("lbu_waitr_hold", {31'b0, mem_stall}, 32'd1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0080_0000;
        tick();
        dmem_rvalid = 1'b0;
        chk("lbu_valid", {31'b0, wb_valid}, 32'd1);
        chk("lbu_lmd", wb_lmd, 32'h0000_0080);

        // Halfword and word loads
        do_load(3'b001, 32'h0000_0002, 5'd10, 32'h8001_7FFF);
        chk("lh_lmd", wb_lmd, 32'hFFFF_8001);
        chk("lh_valid", {31'b0, wb_valid}, 32'd1);
        do_load(3'b101, 32'h0000_0000, 5'd11, 32'h8001_7FFF);
        chk("lhu_lmd", wb_lmd, 32'h0000_7FFF);
        do_load(3'b010, 32'h0000_0000, 5'd12, 32'h8001_7FFF);
        chk("lw_lmd", wb_lmd, 32'h8001_7FFF);
        chk("lw_rd", {27'b0, wb_rd}, 32'd12);

        // Reset while waiting for load data; later rvalid is ignored
        drive_ex(OP_LOAD, 3'b010, 32'h0000_0200, 32'h0, 5'd13, 1'b1);
        tick();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("rstw_in_waitr", {31'b0, mem_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_req", {31'b0, dmem_req}, 32'd0);
        chk("rstw_stall", {31'b0, mem_stall}, 32'd0);
        chk("rstw_wb_valid", {31'b0, wb_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        tick();
        dmem_rvalid = 1'b0;
        chk("rstw_rvalid_ign", {31'b0, wb_valid}, 32'd0);
        chk("rstw_idle", {31'b0, mem_stall}, 32'd0);
        chk("rstw_lmd", wb_lmd, 32'h0);

        // Misaligned word load at 0x101
`ifdef MEM_MISALIGN_TRAP_EN
        drive_ex(OP_LOAD, 3'b010, 32'h0000_0101, 32'h0, 5'd14, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("mis_no_req", {31'b0, dmem_req}, 32'd0);
        chk("mis_stall", {31'b0, mem_stall}, 32'd0);
        chk("mis_valid", {31'b0, wb_valid}, 32'd1);
        chk("mis_exc", {31'b0, misalign_exc}, 32'd1);
        chk("mis_we", {31'b0, wb_write_en}, 32'd0);
        tick();
        chk("mis_exc_clear", {31'b0, misalign_exc}, 32'd0);
        chk("mis_valid_clear", {31'b0, wb_valid}, 32'd0);
`else
        drive_ex(OP_LOAD, 3'b010, 32'h0000_0101, 32'h0, 5'd14, 1'b1);
        tick();
        ex_valid = 1'b0;
        chk("mis_req", {31'b0, dmem_req}, 32'd1);
        chk("mis_addr", dmem_addr, 32'h0000_0100);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1122_3344;
        tick();
        dmem_rvalid = 1'b0;
        chk("mis_lmd", wb_lmd, 32'h1122_3344);
        chk("mis_exc", {31'b0, misalign_exc}, 32'd0);
        chk("mis_we", {31'b0, wb_write_en}, 32'd1);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline; producer side of the memory-to-writeback path.
- Takes execute results and runs loads/stores on a req/gnt/rvalid data-memory port.
- Aligns store lanes and extracts/extends load data into the load memory data (LMD) word.
- Registers opcode, alu_result, LMD, rd and write enable for the writeback stage; stalls upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 32, data/address width; only 32 supported.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  execute stage presents an instruction
- ex_opcode  in  7  instruction opcode
- ex_funct3  in  3  width/sign selector for load/store
- ex_alu_result  in  XLEN  ALU result / effective address
- ex_store_data  in  XLEN  rs2 value for stores
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- mem_stall  out  1  stage busy; upstream holds ex_* and must not advance
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  word-aligned address (bits[1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  load data word
- wb_valid  out  1  writeback bundle valid
- wb_opcode  out  7  registered opcode
- wb_alu_result  out  XLEN  registered ALU result
- wb_lmd  out  XLEN  extended load data
- wb_rd  out  5  registered rd
- wb_write_en  out  1  registered ex_reg_write; forced 0 for stores
- misalign_exc  out  1  misaligned-access flag, aligned with wb_valid (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0 (wb_*, dmem_*, mem_stall, misalign_exc); latched request discarded. Reset mid-transaction drops dmem_req immediately; a later rvalid/gnt is ignored in IDLE.
- Accept condition: ex_valid && !mem_stall. mem_stall = (state != IDLE), combinational from state.
- FSM states IDLE, REQ, WAIT_R.
- IDLE, accepted non-memory op: wb_* loaded next edge, wb_valid=1, wb_lmd=0. Latency 1 cycle.
- IDLE, accepted LOAD/STORE: latch addr, be, wdata, we, rd, funct3, opcode; go to REQ; wb_valid=0 next cycle.
- IDLE, no accept: wb_valid=0 next cycle; other wb_* hold.
- REQ: dmem_req=1, addr/we/be/wdata stable until gnt.
  - gnt with store: wb_valid=1, wb_write_en=0 next edge; go to IDLE.
  - gnt with load: go to WAIT_R.
  - rvalid in REQ is ignored.
- WAIT_R: dmem_req=0. On rvalid: wb_lmd = extracted data, wb_valid=1, wb_write_en = latched reg_write; go to IDLE. rvalid arrives ≥1 cycle after gnt.
- Minimum latency: store 2 cycles (gnt in first REQ cycle); load 3 cycles (rvalid the cycle after gnt).
- Lanes (off = addr[1:0]):
  - SB: be = 4'b0001<<off, wdata = {4{byte}}.
  - SH: be = 4'b0011<<{off[1],1'b0}, wdata = {2{half}}.
  - SW: be = 4'b1111.
- Load extract:
  - LB/LBU: byte at lane off, sign-/zero-extend.
  - LH/LHU: half at lane off[1], sign-/zero-extend.
  - LW: whole word.
  - Unsupported funct3: treated as LW/SW.
- Unbounded gnt/rvalid wait; no timeout.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: a LH/LHU/SH with off[0]=1, or LW/SW with off≠0, is not issued. The next cycle gives wb_valid=1, wb_write_en=0, misalign_exc=1 for that one cycle; FSM stays IDLE.
- Undefined: low address bits are ignored as per lane rules (access forced aligned); misalign_exc tied 0.

Decomposition:
- riscv_pkg holds:
  - OPCODE_LOAD (7'b0000011) and OPCODE_STORE (7'b0100011).
  - funct3 constants F3_B/H/W/BU/HU.
  - typedef enum mem_state_e {IDLE, REQ, WAIT_R}.
- Sub-module load_store_align: combinational; store be/wdata generation and load extract/extend, shared with future cache logic.

Test Plan:
- ADD result 0x0000_1234, rd=5, reg_write=1 → next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=5, wb_write_en=1, mem_stall never high.
- SB addr 0x103, data 0x0000_00A5, gnt after 2 REQ cycles → dmem_be=4'b1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100 held; wb_valid=1, wb_write_en=0 cycle after gnt.
- LB addr 0x102, rdata 0x0080_0000 → wb_lmd=0xFFFF_FF80; same with LBU → 0x0000_0080; mem_stall high from cycle after accept until rvalid.
- LH addr 0x002, rdata 0x8001_7FFF → wb_lmd=0xFFFF_8001; LW → 0x8001_7FFF.
- rst_n low while in WAIT_R, rvalid pulsed after release → dmem_req=0, wb_valid=0, state IDLE, rvalid ignored.
- MEM_MISALIGN_TRAP_EN defined, LW addr 0x101 → no dmem_req; next cycle wb_valid=1, misalign_exc=1, wb_write_en=0.
